ddr3_port_arbiter: RTL and testbench

Shares the single DDR3 master port (address, rd_en/wr_en, 32-bit data, completion strobes) between two requesters inside the Canny core: requester 0 is the frame-store writer, requester 1 is the frame-readback reader. It accepts one transaction at a time with round-robin fairness, holds the memory command until its completion strobe arrives, and returns a one-cycle done pulse (plus read data) to the owning requester. It sits between the algorithm core's pipeline stages and the top-level DDR3 ports.

---
 rtl/ddr3_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter
// Shares the single DDR3 master port between the frame-store writer (req0)
// and the frame-readback reader (req1). One transaction is in flight at a
// time. Ties between the requesters are broken round-robin, and the memory
// command is held until its matching completion strobe arrives.
//
// Optional feature: define DDR3_ARB_TIMEOUT_EN to enable a watchdog. It ends
// a stalled transaction after TIMEOUT_CYCLES busy cycles and raises a sticky
// timeout_err. Without the macro, a transaction waits for its strobe
// indefinitely and timeout_err is tied low.
//
// State table:
//   IDLE | no transaction in flight; ready offered to the granted requester
//   BUSY | command held on the port until its completion strobe (or watchdog)
module ddr3_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [ADDR_WIDTH-1:0] sdram_address,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] write_data_input,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  write_complete,
  input  logic                  read_complete,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    last_grant_q;
  logic                    owner_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    rd_en_q;
  logic                    wr_en_q;
  logic                    done0_q;
  logic                    done1_q;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;

  logic                    grant_d;
  logic                    accept;
  logic                    strobe_hit;
  logic                    timeout_hit;

  // Grant selection: a lone requester wins; on a tie, the one not served last wins
  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_grant_q;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant_d;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_d;
  assign accept     = req0_ready || req1_ready;

  // Only the strobe matching the command type ends the transaction
  assign strobe_hit = write_q ? write_complete : read_complete;

`ifdef DDR3_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_err_q;

  assign timeout_hit = (state_q == BUSY) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  // Watchdog: counts busy cycles since accept; a strobe on the limit cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (accept) begin
        wd_cnt_q <= '0;
      end else if (state_q == BUSY) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (timeout_hit && !strobe_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Transaction FSM: latch on accept, hold the command, then pulse done to the owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            write_q      <= grant_d ? req1_write   : req0_write;
            addr_q       <= grant_d ? req1_address : req0_address;
            wdata_q      <= grant_d ? req1_wdata   : req0_wdata;
            wr_en_q      <= grant_d ? req1_write   : req0_write;
            rd_en_q      <= grant_d ? !req1_write  : !req0_write;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (strobe_hit || timeout_hit) begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            if (owner_q) begin
              done1_q <= 1'b1;
            end else begin
              done0_q <= 1'b1;
            end
            if (strobe_hit && !write_q) begin
              if (owner_q) begin
                rdata1_q <= read_data;
              end else begin
                rdata0_q <= read_data;
              end
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdram_address    = addr_q;
  assign write_data_input = wdata_q;
  assign rd_en            = rd_en_q;
  assign wr_en            = wr_en_q;
  assign busy             = (state_q == BUSY);
  assign req0_done        = done0_q;
  assign req1_done        = done1_q;
  assign req0_rdata       = rdata0_q;
  assign req1_rdata       = rdata1_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Testbench for ddr3_port_arbiter: directed vector table plus hand-written
// sequences for asynchronous reset mid-transaction and the watchdog.
module tb_ddr3_port_arbiter;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_write, req0_ready, req0_done;
  logic [31:0] req0_address, req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_ready, req1_done;
  logic [31:0] req1_address, req1_wdata, req1_rdata;
  logic [31:0] sdram_address, write_data_input, read_data;
  logic        rd_en, wr_en, write_complete, read_complete, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  ddr3_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata),
    .sdram_address(sdram_address), .rd_en(rd_en), .wr_en(wr_en),
    .write_data_input(write_data_input), .read_data(read_data),
    .write_complete(write_complete), .read_complete(read_complete),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic v0; logic w0; logic [31:0] a0; logic [31:0] d0;
    logic v1; logic w1; logic [31:0] a1; logic [31:0] d1;
    logic [31:0] rdin; logic wc; logic rc;
  } in_t;

  typedef struct {
    logic rdy0; logic rdy1;
    logic rd; logic wr; logic bsy; logic dn0; logic dn1;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] rd0; logic [31:0] rd1;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    rst            = v.rst;
    req0_valid     = v.v0;
    req0_write     = v.w0;
    req0_address   = v.a0;
    req0_wdata     = v.d0;
    req1_valid     = v.v1;
    req1_write     = v.w1;
    req1_address   = v.a1;
    req1_wdata     = v.d1;
    read_data      = v.rdin;
    write_complete = v.wc;
    read_complete  = v.rc;
  endtask

  task automatic idle_inputs();
    in_t z;
    z = '{L, L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, 32'h0, L, L};
    drive(z);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Apply one vector from a negedge: check ready before the edge, the rest after it
  task automatic apply(input vec_t v, input int idx);
    drive(v.i);
    #1;
    chk($sformatf("v%0d req0_ready", idx), {31'b0, req0_ready}, {31'b0, v.e.rdy0});
    chk($sformatf("v%0d req1_ready", idx), {31'b0, req1_ready}, {31'b0, v.e.rdy1});
    cycle();
    chk($sformatf("v%0d rd_en", idx),     {31'b0, rd_en},     {31'b0, v.e.rd});
    chk($sformatf("v%0d wr_en", idx),     {31'b0, wr_en},     {31'b0, v.e.wr});
    chk($sformatf("v%0d busy", idx),      {31'b0, busy},      {31'b0, v.e.bsy});
    chk($sformatf("v%0d req0_done", idx), {31'b0, req0_done}, {31'b0, v.e.dn0});
    chk($sformatf("v%0d req1_done", idx), {31'b0, req1_done}, {31'b0, v.e.dn1});
    chk($sformatf("v%0d sdram_address", idx),    sdram_address,    v.e.addr);
    chk($sformatf("v%0d write_data_input", idx), write_data_input, v.e.wd);
    chk($sformatf("v%0d req0_rdata", idx),       req0_rdata,       v.e.rd0);
    chk($sformatf("v%0d req1_rdata", idx),       req1_rdata,       v.e.rd1);
    chk($sformatf("v%0d timeout_err", idx), {31'b0, timeout_err}, 32'h0);
  endtask

  initial begin
    int rd_cycles;
    int done_pulses;

    // inputs: rst, v0,w0,a0,d0, v1,w1,a1,d1, rdin, wc,rc
    // expect: rdy0,rdy1, rd,wr,busy,dn0,dn1, addr,wdata,rdata0,rdata1
    // Reset state
    vecs[0].i  = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h0, L,L};
    vecs[0].e  = '{L,L, L,L,L,L,L, 32'h0,32'h0,32'h0,32'h0};
    // Single read by req1 at 0x100, strobe on the second rd_en cycle
    vecs[1].i  = '{L, L,L,32'h0,32'h0, H,L,32'h100,32'h11111111, 32'h0, L,L};
    vecs[1].e  = '{L,H, H,L,H,L,L, 32'h100,32'h11111111,32'h0,32'h0};
    vecs[2].i  = '{L, L,L,32'h0,32'h0, L,L,32'h999,32'h22, 32'h0, L,L};
    vecs[2].e  = '{L,L, H,L,H,L,L, 32'h100,32'h11111111,32'h0,32'h0};
    vecs[3].i  = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'hDEADBEEF, L,H};
    vecs[3].e  = '{L,L, L,L,L,L,H, 32'h100,32'h11111111,32'h0,32'hDEADBEEF};
    vecs[4].i  = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h0, L,L};
    vecs[4].e  = '{L,L, L,L,L,L,L, 32'h100,32'h11111111,32'h0,32'hDEADBEEF};
    // Write by req0, stray read_complete ignored, write_complete ends it
    vecs[5].i  = '{L, H,H,32'h40,32'h12345678, L,L,32'h0,32'h0, 32'h0, L,L};
    vecs[5].e  = '{H,L, L,H,H,L,L, 32'h40,32'h12345678,32'h0,32'hDEADBEEF};
    vecs[6].i  = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'hBAD0BAD0, L,H};
    vecs[6].e  = '{L,L, L,H,H,L,L, 32'h40,32'h12345678,32'h0,32'hDEADBEEF};
    vecs[7].i  = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h0, L,L};
    vecs[7].e  = '{L,L, L,H,H,L,L, 32'h40,32'h12345678,32'h0,32'hDEADBEEF};
    vecs[8].i  = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h0, H,L};
    vecs[8].e  = '{L,L, L,L,L,H,L, 32'h40,32'h12345678,32'h0,32'hDEADBEEF};
    // Strobes while idle are ignored
    vecs[9].i  = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h55555555, H,H};
    vecs[9].e  = '{L,L, L,L,L,L,L, 32'h40,32'h12345678,32'h0,32'hDEADBEEF};
    // Synchronous-looking reset vector clears everything including rdata
    vecs[10].i = '{H, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h0, L,L};
    vecs[10].e = '{L,L, L,L,L,L,L, 32'h0,32'h0,32'h0,32'h0};
    // Both valid continuously, immediate strobes: grants 0,1,0 at period 2
    vecs[11].i = '{L, H,H,32'h10,32'hA0A0A0A0, H,L,32'h20,32'hB0B0B0B0, 32'h0, L,L};
    vecs[11].e = '{H,L, L,H,H,L,L, 32'h10,32'hA0A0A0A0,32'h0,32'h0};
    vecs[12].i = '{L, H,H,32'h10,32'hA0A0A0A0, H,L,32'h20,32'hB0B0B0B0, 32'h0, H,L};
    vecs[12].e = '{L,L, L,L,L,H,L, 32'h10,32'hA0A0A0A0,32'h0,32'h0};
    vecs[13].i = '{L, H,H,32'h10,32'hA0A0A0A0, H,L,32'h20,32'hB0B0B0B0, 32'h0, L,L};
    vecs[13].e = '{L,H, H,L,H,L,L, 32'h20,32'hB0B0B0B0,32'h0,32'h0};
    vecs[14].i = '{L, H,H,32'h10,32'hA0A0A0A0, H,L,32'h20,32'hB0B0B0B0, 32'hCAFE0001, L,H};
    vecs[14].e = '{L,L, L,L,L,L,H, 32'h20,32'hB0B0B0B0,32'h0,32'hCAFE0001};
    vecs[15].i = '{L, H,H,32'h10,32'hA0A0A0A0, H,L,32'h20,32'hB0B0B0B0, 32'h0, L,L};
    vecs[15].e = '{H,L, L,H,H,L,L, 32'h10,32'hA0A0A0A0,32'h0,32'hCAFE0001};
    vecs[16].i = '{L, H,H,32'h10,32'hA0A0A0A0, H,L,32'h20,32'hB0B0B0B0, 32'h0, H,L};
    vecs[16].e = '{L,L, L,L,L,H,L, 32'h10,32'hA0A0A0A0,32'h0,32'hCAFE0001};
    // Lone req1 write after req0 was served; both strobes on completion
    vecs[17].i = '{L, L,L,32'h0,32'h0, H,H,32'h30,32'hC0C0C0C0, 32'h0, L,L};
    vecs[17].e = '{L,H, L,H,H,L,L, 32'h30,32'hC0C0C0C0,32'h0,32'hCAFE0001};
    vecs[18].i = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h77777777, H,H};
    vecs[18].e = '{L,L, L,L,L,L,H, 32'h30,32'hC0C0C0C0,32'h0,32'hCAFE0001};
    vecs[19].i = '{L, L,L,32'h0,32'h0, L,L,32'h0,32'h0, 32'h0, L,L};
    vecs[19].e = '{L,L, L,L,L,L,L, 32'h30,32'hC0C0C0C0,32'h0,32'hCAFE0001};

    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();

    for (int k = 0; k < 20; k++) begin
      apply(vecs[k], k);
    end

    // Reset asserted mid-read together with the strobe: reset wins, no done
    req0_valid = 1'b1; req0_write = 1'b0; req0_address = 32'h200;
    cycle();
    req0_valid = 1'b0;
    chk("rst_mid rd_en before", {31'b0, rd_en}, 32'h1);
    read_complete = 1'b1; read_data = 32'h99999999; rst = 1'b1;
    #1;
    chk("rst_mid rd_en async",  {31'b0, rd_en}, 32'h0);
    chk("rst_mid busy async",   {31'b0, busy},  32'h0);
    chk("rst_mid addr async",   sdram_address,  32'h0);
    cycle();
    chk("rst_mid req0_done", {31'b0, req0_done}, 32'h0);
    chk("rst_mid req0_rdata", req0_rdata, 32'h0);
    rst = 1'b0; read_complete = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_tie req0_ready", {31'b0, req0_ready}, 32'h1);
    chk("rst_tie req1_ready", {31'b0, req1_ready}, 32'h0);
    idle_inputs();
    cycle();

    // Give req1 a known rdata so the watchdog can be shown not to touch it
    req1_valid = 1'b1; req1_write = 1'b0; req1_address = 32'h280;
    cycle();
    req1_valid = 1'b0;
    read_complete = 1'b1; read_data = 32'h0BADF00D;
    cycle();
    read_complete = 1'b0;
    chk("pre_wd req1_rdata", req1_rdata, 32'h0BADF00D);

    // Watchdog: read with no strobe ever returned
    req1_valid = 1'b1; req1_write = 1'b0; req1_address = 32'h300;
    cycle();
    req1_valid = 1'b0;
    rd_cycles   = 0;
    done_pulses = 0;
    for (int k = 0; k < 22; k++) begin
      if (rd_en) rd_cycles++;
      if (req1_done) done_pulses++;
      cycle();
    end
`ifdef DDR3_ARB_TIMEOUT_EN
    chk("wd rd_en cycles",  rd_cycles,   8);
    chk("wd done pulses",   done_pulses, 1);
    chk("wd timeout_err",   {31'b0, timeout_err}, 32'h1);
    chk("wd busy",          {31'b0, busy}, 32'h0);
    chk("wd req1_rdata",    req1_rdata,  32'h0BADF00D);
`else
    chk("nowd rd_en cycles", rd_cycles,   22);
    chk("nowd done pulses",  done_pulses, 0);
    chk("nowd timeout_err",  {31'b0, timeout_err}, 32'h0);
    chk("nowd busy",         {31'b0, busy}, 32'h1);
    chk("nowd req1_rdata",   req1_rdata,  32'h0BADF00D);
`endif
    rst = 1'b1;
    #1;
    chk("final timeout_err cleared", {31'b0, timeout_err}, 32'h0);
    cycle();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
